stack_unit: RTL and testbench
=============================

STACK_UNIT -- requirements
Module: stack_unit

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits.
REQ-002 Parameter DEPTH, default 32, number of entries; SHALL be a power of two and at least 2.
REQ-003 Parameter PTRW, default log2(DEPTH), pointer width in bits; count uses PTRW+1 bits.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 push  input  1  write din onto the stack.
REQ-007 pop  input  1  remove the top entry and return it on dout.
REQ-008 tos  input  1  return the top entry on dout without removing it.
REQ-009 err_clr  input  1  clears the sticky overflow and underflow flags.
REQ-010 din  input  WIDTH  data to push.
REQ-011 dout  output  WIDTH  registered read data.
REQ-012 dout_valid  output  1  dout was loaded by the operation of the previous cycle.
REQ-013 zero  output  1  equals dout_valid AND (dout == 0).
REQ-014 empty  output  1  count == 0.
REQ-015 full  output  1  count == DEPTH.
REQ-016 count  output  PTRW+1  number of occupied entries.
REQ-017 overflow  output  1  sticky flag: a push was rejected.
REQ-018 underflow  output  1  sticky flag: a pop was rejected.

Function
REQ-019 Storage: DEPTH x WIDTH array; the top entry is at index count-1; count increments on push and decrements on pop.
REQ-020 Operation priority each cycle: push&pop (replace), then push, then pop, then tos, then idle; tos is ignored whenever push or pop is asserted.
REQ-021 Push (pop=0), not full: mem[count] <= din, count+1, dout_valid <= 0, dout holds its value.
REQ-022 Push (pop=0) when full: no write, count unchanged, overflow <= 1, dout_valid <= 0.
REQ-023 Pop (push=0), not empty: dout <= mem[count-1], dout_valid <= 1, count-1; one-cycle latency.
REQ-024 Pop (push=0) when empty: count unchanged, underflow <= 1, dout_valid <= 0, dout holds its value.
REQ-025 Replace (push&pop), count>0 (including full): dout <= old mem[count-1], dout_valid <= 1, mem[count-1] <= din, count unchanged, no error.
REQ-026 Replace when empty: the push executes per REQ-021, underflow <= 1, dout_valid <= 0.
REQ-027 tos, not empty: dout <= mem[count-1], dout_valid <= 1, no state change; tos when empty: dout_valid <= 0, no error flag.
REQ-028 Idle (no push, pop or tos): dout holds its value, dout_valid <= 0; dout is never driven to high impedance.
REQ-029 err_clr clears both sticky flags next cycle; an error raised in the same cycle takes precedence and sets its flag.
REQ-030 empty, full, zero and count are combinational from registered state; no combinational path from any input to any output.

Reset
REQ-031 With rst=1 at posedge clk: count=0, dout=0, dout_valid=0, overflow=0, underflow=0; rst overrides all operations in that cycle.
REQ-032 Array contents are not cleared by reset and are never observable until rewritten, because reads are gated by count.
REQ-033 Reset asserted mid-sequence discards in-flight operations; the first operation after reset deassertion behaves as on an empty stack.

Verification
REQ-034 Reset, then push 0x11, 0x22, 0x33, then pop x3 -> dout 0x33, 0x22, 0x11 on consecutive cycles with dout_valid=1; count 3->0; empty=1 at end.
REQ-035 DEPTH=4: push 5 values -> full=1 after the 4th push; 5th push sets overflow=1, count stays 4; pops return the first 4 values in LIFO order.
REQ-036 Empty stack: pop -> underflow=1, dout_valid=0; err_clr -> underflow=0 next cycle; err_clr together with a pop on an empty stack -> underflow stays 1.
REQ-037 Stack holding 0x05: push&pop with din=0x09 -> dout=0x05, dout_valid=1, count=1; tos -> dout=0x09.
REQ-038 Push 0x00, then tos -> dout=0x00, zero=1, count=1; next idle cycle -> dout_valid=0, zero=0, dout=0x00.
REQ-039 Push 3 values, assert rst for one cycle during a pop -> count=0, dout=0, flags 0; push 0x7F then pop -> dout=0x7F.

Source files
------------

// File: rtl/stack_unit_if.sv
// ============================================================================
// Module   : stack_unit_if
// Brief    : Command and status bundle for the LIFO stack unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface stack_unit_if #(
    parameter int WIDTH = 8,
    parameter int PTRW  = 5
);
    logic             push;
    logic             pop;
    logic             tos;
    logic             err_clr;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             zero;
    logic             empty;
    logic             full;
    logic [PTRW:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output push, pop, tos, err_clr, din,
        input  dout, dout_valid, zero, empty, full, count, overflow, underflow
    );

    modport slave (
        input  push, pop, tos, err_clr, din,
        output dout, dout_valid, zero, empty, full, count, overflow, underflow
    );
endinterface

`default_nettype wire

// File: rtl/stack_unit.sv
// ============================================================================
// Module   : stack_unit
// Brief    : LIFO stack with push/pop/replace/peek, registered read data and
//            sticky overflow/underflow flags.
// Revision : 1.0
// ============================================================================
`default_nettype none

module stack_unit #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32,
    parameter int PTRW  = $clog2(DEPTH)
) (
    input  wire logic       clk,
    input  wire logic       rst,
    stack_unit_if.slave     bus
);
    localparam logic [PTRW:0]   C_FULL    = (PTRW+1)'(DEPTH);
    localparam logic [PTRW:0]   C_CNT_ONE = (PTRW+1)'(1);
    localparam logic [PTRW-1:0] C_PTR_ONE = PTRW'(1);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PTRW:0]    count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic             w_empty;
    logic             w_full;
    logic [PTRW-1:0]  w_top;
    logic             w_we;
    logic [PTRW-1:0]  w_waddr;

    assign w_empty = (count_q == '0);
    assign w_full  = (count_q == C_FULL);
    // Wraps to DEPTH-1 when full, since count_q[PTRW-1:0] is then zero.
    assign w_top   = count_q[PTRW-1:0] - C_PTR_ONE;

    always_comb begin
        count_d      = count_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        overflow_d   = bus.err_clr ? 1'b0 : overflow_q;
        underflow_d  = bus.err_clr ? 1'b0 : underflow_q;
        w_we         = 1'b0;
        w_waddr      = count_q[PTRW-1:0];

        if (bus.push && bus.pop) begin
            if (!w_empty) begin
                dout_d       = mem[w_top];
                dout_valid_d = 1'b1;
                w_we         = 1'b1;
                w_waddr      = w_top;
            end else begin
                // Empty replace degrades to a plain push plus an underflow.
                w_we        = 1'b1;
                count_d     = count_q + C_CNT_ONE;
                underflow_d = 1'b1;
            end
        end else if (bus.push) begin
            if (w_full) begin
                overflow_d = 1'b1;
            end else begin
                w_we    = 1'b1;
                count_d = count_q + C_CNT_ONE;
            end
        end else if (bus.pop) begin
            if (w_empty) begin
                underflow_d = 1'b1;
            end else begin
                dout_d       = mem[w_top];
                dout_valid_d = 1'b1;
                count_d      = count_q - C_CNT_ONE;
            end
        end else if (bus.tos) begin
            if (!w_empty) begin
                dout_d       = mem[w_top];
                dout_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            count_q      <= count_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    // Array is not reset; stale entries stay hidden behind count_q.
    always_ff @(posedge clk) begin
        if (w_we && !rst) begin
            mem[w_waddr] <= bus.din;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.zero       = dout_valid_q && (dout_q == '0);
    assign bus.empty      = w_empty;
    assign bus.full       = w_full;
    assign bus.count      = count_q;
    assign bus.overflow   = overflow_q;
    assign bus.underflow  = underflow_q;

endmodule

`default_nettype wire

// File: tb/tb_stack_unit.sv
// ============================================================================
// Module   : tb_stack_unit
// Brief    : Directed scoreboard bench for stack_unit (DEPTH=4, WIDTH=8).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_stack_unit;
    localparam int C_WIDTH = 8;
    localparam int C_DEPTH = 4;
    localparam int C_PTRW  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_total = 0;
    int   n_bad   = 0;
    logic [7:0] exp_q [$];

    stack_unit_if #(.WIDTH(C_WIDTH), .PTRW(C_PTRW)) bus ();

    stack_unit #(.WIDTH(C_WIDTH), .DEPTH(C_DEPTH), .PTRW(C_PTRW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One cycle of stimulus; an expected read value is queued for the monitor.
    task automatic op(input logic p, input logic q, input logic t, input logic c,
                      input logic [7:0] d, input bit expv, input logic [7:0] expd);
        @(negedge clk);
        bus.push = p; bus.pop = q; bus.tos = t; bus.err_clr = c; bus.din = d;
        if (expv) exp_q.push_back(expd);
        @(posedge clk);
        #1;
        chk("dout_valid", int'(bus.dout_valid), int'(expv));
    endtask

    task automatic push(input logic [7:0] d); op(1, 0, 0, 0, d, 0, 8'h00); endtask
    task automatic pop_exp(input logic [7:0] e); op(0, 1, 0, 0, 8'h00, 1, e); endtask
    task automatic idle(); op(0, 0, 0, 0, 8'h00, 0, 8'h00); endtask

    // Monitor: every valid read must match the oldest queued expectation.
    always @(posedge clk) begin
        #1;
        if (bus.dout_valid) begin
            n_total++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_read: got 0x%0h expected none", bus.dout);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (bus.dout !== e) begin
                    n_bad++;
                    $display("FAIL read_data: got 0x%0h expected 0x%0h", bus.dout, e);
                end
            end
        end
    end

    initial begin
        bus.push = 0; bus.pop = 0; bus.tos = 0; bus.err_clr = 0; bus.din = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_count", int'(bus.count), 0);
        chk("rst_empty", int'(bus.empty), 1);
        chk("rst_dout", int'(bus.dout), 0);
        chk("rst_flags", int'({bus.overflow, bus.underflow}), 0);

        // Basic LIFO order
        push(8'h11); push(8'h22); push(8'h33);
        chk("count3", int'(bus.count), 3);
        pop_exp(8'h33); pop_exp(8'h22); pop_exp(8'h11);
        chk("count0", int'(bus.count), 0);
        chk("empty_end", int'(bus.empty), 1);

        // Fill to full, overflow, drain
        push(8'hA1); push(8'hA2); push(8'hA3);
        chk("not_full3", int'(bus.full), 0);
        push(8'hA4);
        chk("full4", int'(bus.full), 1);
        push(8'hA5);
        chk("overflow", int'(bus.overflow), 1);
        chk("count_ovf", int'(bus.count), 4);
        pop_exp(8'hA4); pop_exp(8'hA3); pop_exp(8'hA2); pop_exp(8'hA1);
        chk("ovf_sticky", int'(bus.overflow), 1);
        op(0, 0, 0, 1, 8'h00, 0, 8'h00);
        chk("ovf_clr", int'(bus.overflow), 0);

        // Underflow and err_clr precedence
        op(0, 1, 0, 0, 8'h00, 0, 8'h00);
        chk("underflow", int'(bus.underflow), 1);
        op(0, 0, 0, 1, 8'h00, 0, 8'h00);
        chk("unf_clr", int'(bus.underflow), 0);
        op(0, 1, 0, 1, 8'h00, 0, 8'h00);
        chk("unf_clr_pop", int'(bus.underflow), 1);
        op(0, 0, 0, 1, 8'h00, 0, 8'h00);

        // Replace and peek
        push(8'h05);
        op(1, 1, 0, 0, 8'h09, 1, 8'h05);
        chk("replace_count", int'(bus.count), 1);
        chk("replace_noerr", int'({bus.overflow, bus.underflow}), 0);
        op(0, 0, 1, 0, 8'h00, 1, 8'h09);
        pop_exp(8'h09);

        // Zero flag
        push(8'h00);
        op(0, 0, 1, 0, 8'h00, 1, 8'h00);
        chk("zero_set", int'(bus.zero), 1);
        chk("zero_count", int'(bus.count), 1);
        idle();
        chk("zero_idle", int'(bus.zero), 0);
        chk("dout_hold", int'(bus.dout), 0);
        pop_exp(8'h00);
        push(8'h66);
        op(0, 0, 1, 0, 8'h00, 1, 8'h66);
        chk("zero_nz", int'(bus.zero), 0);
        pop_exp(8'h66);

        // Replace on empty: push plus underflow
        op(1, 1, 0, 0, 8'h44, 0, 8'h00);
        chk("repl_empty_count", int'(bus.count), 1);
        chk("repl_empty_unf", int'(bus.underflow), 1);
        pop_exp(8'h44);
        op(0, 0, 0, 1, 8'h00, 0, 8'h00);

        // Replace on full, then tos when empty
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        op(1, 1, 0, 0, 8'h55, 1, 8'h04);
        chk("repl_full_count", int'(bus.count), 4);
        chk("repl_full_noerr", int'(bus.overflow), 0);
        pop_exp(8'h55); pop_exp(8'h03); pop_exp(8'h02); pop_exp(8'h01);
        op(0, 0, 1, 0, 8'h00, 0, 8'h00);
        chk("tos_empty_noerr", int'({bus.overflow, bus.underflow}), 0);

        // Reset mid-sequence
        push(8'hB1); push(8'hB2); push(8'hB3);
        @(negedge clk);
        rst = 1'b1; bus.pop = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; bus.pop = 1'b0;
        chk("midrst_count", int'(bus.count), 0);
        chk("midrst_dout", int'(bus.dout), 0);
        chk("midrst_dv", int'(bus.dout_valid), 0);
        chk("midrst_flags", int'({bus.overflow, bus.underflow}), 0);
        push(8'h7F);
        pop_exp(8'h7F);
        idle();

        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

`default_nettype wire
